instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 32'h00000000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the prefetch buffer entry count (power of two, >= 2).
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 mem_req_o  output  1  instruction memory read request.
REQ-006 mem_addr_o  output  32  word-aligned fetch address, valid while mem_req_o=1.
REQ-007 mem_ack_i  input  1  memory response strobe, one cycle per request.
REQ-008 mem_data_i  input  32  instruction word, valid when mem_ack_i=1.
REQ-009 instr_valid_o  output  1  buffer head holds an instruction for decode.
REQ-010 instr_o  output  32  buffer head instruction word.
REQ-011 instr_pc_o  output  32  address of instr_o.
REQ-012 instr_ready_i  input  1  decode accepts instr_o this cycle.
REQ-013 branch_i  input  1  redirect strobe, one cycle.
REQ-014 branch_target_i  output-facing input  32  redirect address; bits [1:0] SHALL be ignored and treated as 2'b00.
REQ-015 fifo_count_o  output  $clog2(DEPTH)+1  number of valid buffer entries.

Function
REQ-016 The module SHALL keep one fetch PC register, advancing by 4 per issued request, wrapping 32'hFFFFFFFC -> 32'h00000000.
REQ-017 At most one memory request SHALL be outstanding; states: IDLE (no request), WAIT (request outstanding), WAIT_DROP (outstanding, response to be discarded).
REQ-018 IDLE -> WAIT when buffer count plus outstanding count < DEPTH and branch_i=0; mem_req_o SHALL assert in the following cycle, registered.
REQ-019 mem_req_o and mem_addr_o SHALL stay constant from assertion until the cycle mem_ack_i=1, inclusive.
REQ-020 In WAIT, mem_ack_i=1 SHALL push {mem_data_i, mem_addr_o} into the buffer and return to IDLE; the entry SHALL be visible on instr_valid_o in the next cycle (1-cycle ack-to-valid latency).
REQ-021 mem_ack_i in IDLE SHALL be ignored.
REQ-022 The buffer SHALL be show-ahead: instr_o/instr_pc_o reflect the head entry combinationally; instr_valid_o = (count != 0) && !branch_i.
REQ-023 A pop SHALL occur when instr_valid_o=1 and instr_ready_i=1; simultaneous push and pop SHALL leave count unchanged.
REQ-024 The buffer SHALL never overflow: a push SHALL always have a reserved slot per REQ-018.
REQ-025 branch_i=1 SHALL flush all buffer entries, load fetch PC with {branch_target_i[31:2],2'b00}, and override any same-cycle pop.
REQ-026 branch_i=1 in WAIT without mem_ack_i SHALL move to WAIT_DROP; the outstanding request SHALL remain asserted with its original address until acknowledged.
REQ-027 In WAIT_DROP, mem_ack_i=1 SHALL discard mem_data_i and go to IDLE; a further branch_i SHALL stay in WAIT_DROP with the newest target.
REQ-028 branch_i=1 coincident with mem_ack_i SHALL discard that response and go to IDLE.
REQ-029 Consecutive fetches SHALL be issued back-to-back: IDLE with room SHALL re-request in the cycle after an ack.

Reset
REQ-030 While rst=0 the module SHALL asynchronously force: state IDLE, fetch PC RESET_PC, count 0, mem_req_o 0, mem_addr_o 0, instr_valid_o 0, instr_o 0, instr_pc_o 0, fifo_count_o 0.
REQ-031 Reset asserted mid-request SHALL abandon the request; no response data from before reset SHALL enter the buffer.
REQ-032 The first request after rst rises SHALL be to RESET_PC, mem_req_o asserting one cycle after release.

Verification
REQ-033 Reset release, memory acking every request one cycle later with data=addr, instr_ready_i=1 -> instr_pc_o sequence 0x0,0x4,0x8,... with instr_o equal to instr_pc_o, no gaps beyond the single-outstanding limit.
REQ-034 instr_ready_i=0, DEPTH=4 -> exactly 4 entries fetched, fifo_count_o=4, mem_req_o stays 0; instr_ready_i=1 for one cycle -> one new request to 0x10.
REQ-035 branch_i with target 0x103 while request to 0x8 outstanding -> mem_addr_o holds 0x8 until ack, that data discarded, next request to 0x100, instr_valid_o low until 0x100 returns.
REQ-036 branch_i in the same cycle as mem_ack_i and a pop -> buffer empty, response dropped, next request to target, fifo_count_o=0.
REQ-037 Branch to 0xFFFFFFF8, two fetches -> addresses 0xFFFFFFF8, 0xFFFFFFFC, then 0x00000000.
REQ-038 rst pulsed low while mem_req_o=1, stale mem_ack_i after release -> ack ignored, first valid instruction has instr_pc_o=RESET_PC.

Source files
------------

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a single-outstanding fetch engine feeding a show-ahead
// prefetch buffer, with branch redirect that flushes the buffer and squashes in-flight data.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     mem_req_o,
  output logic [31:0]              mem_addr_o,
  input  logic                     mem_ack_i,
  input  logic [31:0]              mem_data_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  input  logic                     instr_ready_i,
  input  logic                     branch_i,
  input  logic [31:0]              branch_target_i,
  output logic [$clog2(DEPTH):0]   fifo_count_o,
  output logic [1:0]               state_o
);

  // Handshakes: a memory request is held (mem_req_o/mem_addr_o stable) until the
  // cycle mem_ack_i=1; the decode side pops when instr_valid_o && instr_ready_i.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT      = 2'd1,
    S_WAIT_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     addr_q, addr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     buf_data_q [DEPTH];
  logic [31:0]     buf_data_d [DEPTH];
  logic [31:0]     buf_pc_q   [DEPTH];
  logic [31:0]     buf_pc_d   [DEPTH];

  logic            room;
  logic            push;
  logic            pop;
  logic            unused_tgt;

  // Only one request can be in flight, so in IDLE the outstanding count is zero.
  assign room          = (count_q < DEPTH_C);
  assign push          = (state_q == S_WAIT) && mem_ack_i && !branch_i;
  assign instr_valid_o = (count_q != '0) && !branch_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign unused_tgt    = ^branch_target_i[1:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (!branch_i && room) begin
          state_d = S_WAIT;
          addr_d  = pc_q;
          pc_d    = pc_q + 32'd4;
        end
      end
      S_WAIT: begin
        if (mem_ack_i)     state_d = S_IDLE;
        else if (branch_i) state_d = S_WAIT_DROP;
      end
      S_WAIT_DROP: begin
        if (mem_ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (branch_i) pc_d = {branch_target_i[31:2], 2'b00};
  end

  always_comb begin
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (branch_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        buf_data_d[wr_ptr_q] = mem_data_i;
        buf_pc_d[wr_ptr_q]   = addr_q;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_data_q[i] <= '0;
        buf_pc_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
    end
  end

  // Head is gated by occupancy so an empty buffer presents zeros, as in reset.
  assign mem_req_o    = (state_q != S_IDLE);
  assign mem_addr_o   = addr_q;
  assign instr_o      = (count_q != '0) ? buf_data_q[rd_ptr_q] : '0;
  assign instr_pc_o   = (count_q != '0) ? buf_pc_q[rd_ptr_q] : '0;
  assign fifo_count_o = count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of the fetch unit.
module tb_instruction_fetch;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic                   clk;
  logic                   rst;
  logic                   mem_req_o;
  logic [31:0]            mem_addr_o;
  logic                   mem_ack_i;
  logic [31:0]            mem_data_i;
  logic                   instr_valid_o;
  logic [31:0]            instr_o;
  logic [31:0]            instr_pc_o;
  logic                   instr_ready_i;
  logic                   branch_i;
  logic [31:0]            branch_target_i;
  logic [$clog2(DEPTH):0] fifo_count_o;
  logic [1:0]             state_o;

  instruction_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .instr_pc_o      (instr_pc_o),
    .instr_ready_i   (instr_ready_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .fifo_count_o    (fifo_count_o),
    .state_o         (state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_drop;
  int          m_age;
  bit          mdl_pop, mdl_push, mdl_issue;
  ent_t        mdl_e;

  bit          ready_r;
  int          lat;
  logic [31:0] salt;
  logic [31:0] pop_log[$];
  logic [31:0] req_log[$];
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: buffer is a queue, the memory port is one in-flight record with a drop flag.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_out  = 1'b0;
      m_drop = 1'b0;
      m_addr = 32'h0;
      m_age  = 0;
    end else begin
      mdl_pop   = (mq.size() != 0) && !branch_i && instr_ready_i;
      mdl_push  = m_out && !m_drop && mem_ack_i && !branch_i;
      mdl_issue = !m_out && !branch_i && (mq.size() < DEPTH);
      mdl_e.pc   = m_addr;
      mdl_e.data = mem_data_i;
      if (m_out) begin
        if (mem_ack_i) m_out = 1'b0;
        else begin
          if (branch_i) m_drop = 1'b1;
          m_age++;
        end
      end
      if (mdl_issue) begin
        m_out  = 1'b1;
        m_drop = 1'b0;
        m_addr = m_pc;
        m_pc   = m_pc + 32'd4;
        m_age  = 0;
      end
      if (branch_i) begin
        mq.delete();
        m_pc = {branch_target_i[31:2], 2'b00};
      end else begin
        if (mdl_pop) void'(mq.pop_front());
        if (mdl_push) mq.push_back(mdl_e);
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("rst_mem_req", 32'(mem_req_o), 32'h0);
      chk("rst_mem_addr", mem_addr_o, 32'h0);
      chk("rst_instr_valid", 32'(instr_valid_o), 32'h0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_instr_pc", instr_pc_o, 32'h0);
      chk("rst_fifo_count", 32'(fifo_count_o), 32'h0);
    end else begin
      chk("mem_req", 32'(mem_req_o), 32'(m_out));
      if (m_out) chk("mem_addr", mem_addr_o, m_addr);
      chk("instr_valid", 32'(instr_valid_o), 32'((mq.size() != 0) && !branch_i));
      chk("fifo_count", 32'(fifo_count_o), 32'(mq.size()));
      if (mq.size() != 0) begin
        chk("instr", instr_o, mq[0].data);
        chk("instr_pc", instr_pc_o, mq[0].pc);
      end
      if (instr_valid_o && instr_ready_i) pop_log.push_back(instr_pc_o);
      if (mem_req_o && mem_ack_i) req_log.push_back(mem_addr_o);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply(input bit br, input logic [31:0] tgt, input bit stale);
    branch_i        = br;
    branch_target_i = tgt;
    instr_ready_i   = ready_r;
    if (m_out && (m_age >= lat)) begin
      mem_ack_i  = 1'b1;
      mem_data_i = m_addr ^ salt;
    end else begin
      mem_ack_i  = stale;
      mem_data_i = $urandom;
    end
  endtask

  task automatic step(input bit br, input logic [31:0] tgt);
    @(negedge clk);
    apply(br, tgt, 1'b0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(1'b0, 32'h0, 1'b0);
    run(2);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    apply(1'b0, 32'h0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    mem_ack_i = 1'b0;
    mem_data_i = 32'h0;
    instr_ready_i = 1'b0;
    branch_i = 1'b0;
    branch_target_i = 32'h0;
    ready_r = 1'b0;
    lat = 1;
    salt = 32'h0;
    run(3);

    // Streaming: ack one cycle after request, data = address, always ready.
    ready_r = 1'b1;
    pop_log.delete();
    release_rst();
    run(40);
    chk("s33_throughput", 32'(pop_log.size() >= 12), 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (i < pop_log.size()) chk("s33_pc_seq", pop_log[i], 32'(4 * i));
      else chk("s33_pc_len", 32'(pop_log.size()), 32'h4);
    end

    // Fill with decode stalled, then a single pop frees one slot.
    do_reset();
    ready_r = 1'b0;
    lat = 1;
    release_rst();
    run(20);
    #3;
    chk("s34_count", 32'(fifo_count_o), 32'h4);
    chk("s34_req_idle", 32'(mem_req_o), 32'h0);
    chk("s34_head_pc", instr_pc_o, 32'h0);
    ready_r = 1'b1;
    step(1'b0, 32'h0);
    ready_r = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 32'h0);
      #3;
      if (mem_req_o) break;
    end
    chk("s34_new_req", 32'(mem_req_o), 32'h1);
    chk("s34_new_addr", mem_addr_o, 32'h10);
    run(5);

    // Branch while the request to 0x8 is outstanding.
    do_reset();
    ready_r = 1'b0;
    lat = 3;
    release_rst();
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_out && (m_addr == 32'h8)) begin
        apply(1'b1, 32'h103, 1'b0);
        found = 1'b1;
        break;
      end
      apply(1'b0, 32'h0, 1'b0);
    end
    chk("s35_found", 32'(found), 32'h1);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0);
      #3;
      if (mem_req_o && (mem_addr_o !== 32'h8)) break;
      if (mem_req_o) chk("s35_hold", mem_addr_o, 32'h8);
    end
    chk("s35_next_addr", mem_addr_o, 32'h100);
    chk("s35_no_valid", 32'(instr_valid_o), 32'h0);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 32'h0);
      #3;
      if (instr_valid_o) break;
    end
    chk("s35_first_pc", instr_pc_o, 32'h100);

    // Branch coincident with an ack and a pop.
    do_reset();
    ready_r = 1'b0;
    lat = 1;
    release_rst();
    run(14);
    ready_r = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_out && (m_age >= lat) && (mq.size() != 0)) begin
        apply(1'b1, 32'h200, 1'b0);
        found = 1'b1;
        break;
      end
      apply(1'b0, 32'h0, 1'b0);
    end
    chk("s36_found", 32'(found), 32'h1);
    step(1'b0, 32'h0);
    #3;
    chk("s36_count", 32'(fifo_count_o), 32'h0);
    chk("s36_req_low", 32'(mem_req_o), 32'h0);
    step(1'b0, 32'h0);
    #3;
    chk("s36_req", 32'(mem_req_o), 32'h1);
    chk("s36_addr", mem_addr_o, 32'h200);
    run(5);

    // Address wrap at the top of the address space.
    do_reset();
    ready_r = 1'b0;
    lat = 1;
    req_log.delete();
    @(negedge clk);
    rst = 1'b1;
    apply(1'b1, 32'hFFFF_FFF8, 1'b0);
    run(12);
    if (req_log.size() >= 3) begin
      chk("s37_a0", req_log[0], 32'hFFFF_FFF8);
      chk("s37_a1", req_log[1], 32'hFFFF_FFFC);
      chk("s37_a2", req_log[2], 32'h0000_0000);
    end else chk("s37_len", 32'(req_log.size()), 32'h3);

    // Reset mid-request, then a stale ack right after release.
    ready_r = 1'b1;
    lat = 3;
    salt = 32'h5A5A_0000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_out) begin
        rst = 1'b0;
        apply(1'b0, 32'h0, 1'b0);
        break;
      end
      apply(1'b0, 32'h0, 1'b0);
    end
    chk("s38_rst_hit", 32'(rst), 32'h0);
    run(2);
    @(negedge clk);
    rst = 1'b1;
    pop_log.delete();
    apply(1'b0, 32'h0, 1'b1);
    run(15);
    if (pop_log.size() > 0) chk("s38_first_pc", pop_log[0], RESET_PC);
    else chk("s38_len", 32'(pop_log.size()), 32'h1);

    // Random traffic.
    salt = $urandom;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      ready_r = ($urandom_range(0, 3) != 0);
      lat = $urandom_range(0, 3);
      apply(($urandom_range(0, 19) == 0), $urandom,
            !m_out && ($urandom_range(0, 15) == 0));
    end
    run(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
